mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port RAM arbiter between the instruction cache and the data cache. Accepts word requests from both caches and serializes them onto one RAM port. Locks the port for a data cache two-word block transfer and alternates grants when both caches are waiting. Sits between the cache pair and the RAM model, in place of a direct cache-to-RAM connection.

## Interface
- No parameters. Word width is 32 bits. RAM state encoding is fixed: FREE=2'd0, BUSY=2'd1, ACCESS=2'd2, ERROR=2'd3.
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low only in the cycle the icache word is delivered.
- iload  out  32  icache read data; valid when iwait low.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address; bit 2 selects the word within a block.
- dstore  in  32  dcache write data.
- dwait  out  1  low only in the cycle the dcache word completes.
- dload  out  32  dcache read data; valid when dwait low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status, combinational from RAM.

## Operation
- State register values: IDLE, DSERV, ISERV. Also 1-bit last_d (the last completed grant was dcache) and 1-bit dlock.
- IDLE
  - All RAM enables are 0. ramaddr, ramstore and both load outputs are 0.
  - If dREN|dWEN and iREN are both high, grant the side not last served: last_d=1 gives ISERV, otherwise DSERV.
  - If only one side requests, go to its SERV state.
  - The transition takes effect at the next edge.
- DSERV
  - ramaddr=daddr and ramstore=dstore.
  - ramWEN=dWEN. ramREN=dREN & ~dWEN, so a write wins if both are set.
  - dload=ramload.
  - dwait=0 when ramstate==ACCESS, else 1.
- ISERV
  - ramaddr=iaddr, ramREN=iREN, ramWEN=0.
  - iload=ramload.
  - iwait=0 when ramstate==ACCESS, else 1.
- The non-granted side's wait is always 1 and its load is 0.
- Completion, on ramstate==ACCESS:
  - In ISERV: go to IDLE and set last_d=0.
  - In DSERV with daddr[2]==0: set dlock=1 and stay in DSERV for the second word.
  - In DSERV with daddr[2]==1: clear dlock, set last_d=1 and go to IDLE.
- While dlock=1, an iREN is not granted. It waits until the block finishes.
- Request drop: if the granted side deasserts all of its enables in a SERV state, go to IDLE next cycle and clear dlock. last_d is unchanged.
- ramstate BUSY, FREE or ERROR while granted: hold state and keep wait=1. The RAM retries, and the arbiter adds no extra handling.
- Reset: state=IDLE, last_d=0, dlock=0.
  - Outputs after reset: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
  - Reset mid-transaction aborts the grant immediately at that edge. RAM enables drop in the following cycle.

## Timing
- Grant latency: the request is seen in IDLE at cycle N, and RAM enables are asserted in cycle N+1.
- Best case the word completes in cycle N+1 (ACCESS the same cycle), so a single word takes at least 2 cycles.
- Back-to-back:
  - After a completion, the arbiter spends 1 IDLE cycle before the next grant.
  - Exception: the second word of a locked dcache block, which needs no IDLE cycle. Its RAM enables are asserted in the cycle after the first word's ACCESS.
- Outputs:
  - RAM enables, address and data are combinational from the current state and the granted requester's inputs.
  - Wait and load outputs are combinational from the current state and ramstate.
- ramstate==ACCESS in IDLE is ignored.

## Test plan
- Reset, then RST=0 with no requests:
  - iwait=1, dwait=1, ramREN=0, ramWEN=0 for 5 cycles.
  - State stays IDLE.
- iREN=1, iaddr=0x40, RAM returns ACCESS with ramload=0xDEADBEEF 2 cycles after grant:
  - ramREN=1 and ramaddr=0x40 from cycle 1.
  - iwait=0 and iload=0xDEADBEEF exactly in cycle 3.
  - IDLE in cycle 4.
- dWEN block write to 0x100 then 0x104, both taking 1-cycle ACCESS, with iREN=1 held throughout:
  - Both dcache words complete in consecutive cycles (dlock).
  - ramWEN=1 with ramstore=dstore in each.
  - iREN is granted only after the 0x104 word.
- dREN and iREN asserted together from reset (last_d=0):
  - DSERV is granted first.
  - After its block, ISERV is granted next even though dREN is reasserted.
- dREN=1 granted and held BUSY for 3 cycles, then dREN dropped:
  - Arbiter returns to IDLE next cycle.
  - A pending iREN is granted the cycle after.
- RST asserted in the cycle after ACCESS of word 0x200 (first word of a block):
  - Next cycle is IDLE with dlock=0, dwait=1 and ramREN=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the icache and dcache. Serializes word requests,
// locks the port across a two-word dcache block and alternates grants under contention.
module mem_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_last_d;
  logic   r_dlock;
  logic   w_next_last_d;
  logic   w_next_dlock;
  logic   w_dreq;
  logic   w_access;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == RAM_ACCESS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_dlock  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_last_d <= w_next_last_d;
      r_dlock  <= w_next_dlock;
    end
  end

  // BUSY/FREE/ERROR while granted simply hold; the RAM retries on its own.
  always_comb begin
    w_next_state  = r_state;
    w_next_last_d = r_last_d;
    w_next_dlock  = r_dlock;
    case (r_state)
      IDLE: begin
        if (w_dreq && iREN)
          w_next_state = r_last_d ? ISERV : DSERV;
        else if (w_dreq)
          w_next_state = DSERV;
        else if (iREN)
          w_next_state = ISERV;
      end
      DSERV: begin
        if (!w_dreq) begin
          w_next_state = IDLE;
          w_next_dlock = 1'b0;
        end else if (w_access) begin
          if (!daddr[2]) begin
            w_next_dlock = 1'b1;
          end else begin
            w_next_dlock  = 1'b0;
            w_next_last_d = 1'b1;
            w_next_state  = IDLE;
          end
        end
      end
      ISERV: begin
        if (!iREN) begin
          w_next_state = IDLE;
          w_next_dlock = 1'b0;
        end else if (w_access) begin
          w_next_last_d = 1'b0;
          w_next_state  = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Non-granted side always sees wait=1 and load=0.
  always_comb begin
    iwait    = 1'b1;
    iload    = 32'd0;
    dwait    = 1'b1;
    dload    = 32'd0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    case (r_state)
      DSERV: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = ramload;
        dwait    = ~w_access;
      end
      ISERV: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iload   = ramload;
        iwait   = ~w_access;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both caches and the RAM, driving
// ramstate/ramload per cycle and checking outputs against hand-computed values.
module tb_mem_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = FREE;
    RST = 1;
    tick();
    tick();
    RST = 0;
  endtask

  function automatic logic [3:0] ctl();
    return {iwait, dwait, ramREN, ramWEN};
  endfunction

  task automatic test_reset();
    do_reset();
    iaddr = 32'h123; daddr = 32'h456; dstore = 32'h789;
    ramload = 32'hCAFE; ramstate = ACCESS;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (ctl() !== 4'b1100) begin
        n_fail++; $display("FAIL reset_ctl[%0d]: got %b expected 1100", c, ctl());
      end
      n_checks++;
      if ({ramaddr, ramstore, iload, dload} !== 128'd0) begin
        n_fail++;
        $display("FAIL reset_data[%0d]: got %h %h %h %h expected all 0", c, ramaddr, ramstore, iload, dload);
      end
      tick();
    end
  endtask

  task automatic test_iread();
    do_reset();
    iREN = 1; iaddr = 32'h40; #1;
    n_checks++;
    if (ctl() !== 4'b1100) begin n_fail++; $display("FAIL iread_c0: got %b expected 1100", ctl()); end
    tick();
    for (int c = 1; c <= 2; c++) begin
      ramstate = BUSY; #1;
      n_checks++;
      if (ctl() !== 4'b1110 || ramaddr !== 32'h40) begin
        n_fail++; $display("FAIL iread_c%0d: got %b addr %h expected 1110 addr 40", c, ctl(), ramaddr);
      end
      tick();
    end
    ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    n_checks++;
    if (ctl() !== 4'b0110 || iload !== 32'hDEADBEEF || dload !== 32'd0) begin
      n_fail++; $display("FAIL iread_c3: got %b iload %h dload %h expected 0110 DEADBEEF 0", ctl(), iload, dload);
    end
    tick();
    iREN = 0; ramstate = FREE; #1;
    n_checks++;
    if (ctl() !== 4'b1100 || iload !== 32'd0) begin
      n_fail++; $display("FAIL iread_c4: got %b iload %h expected 1100 0", ctl(), iload);
    end
    tick();
  endtask

  task automatic test_dblock();
    do_reset();
    dWEN = 1; daddr = 32'h100; dstore = 32'hA1; iREN = 1; iaddr = 32'h80; #1;
    n_checks++;
    if (ctl() !== 4'b1100) begin n_fail++; $display("FAIL dblock_c0: got %b expected 1100", ctl()); end
    tick();
    ramstate = ACCESS; ramload = 32'h77; #1;
    n_checks++;
    if (ctl() !== 4'b1001 || ramaddr !== 32'h100 || ramstore !== 32'hA1 || iload !== 32'd0) begin
      n_fail++;
      $display("FAIL dblock_w0: got %b addr %h store %h iload %h expected 1001 100 a1 0", ctl(), ramaddr, ramstore, iload);
    end
    tick();
    dREN = 1; daddr = 32'h104; dstore = 32'hB2; #1;
    n_checks++;
    if (ctl() !== 4'b1001 || ramaddr !== 32'h104 || ramstore !== 32'hB2) begin
      n_fail++; $display("FAIL dblock_w1: got %b addr %h store %h expected 1001 104 b2", ctl(), ramaddr, ramstore);
    end
    tick();
    dREN = 0; dWEN = 0; ramstate = FREE; #1;
    n_checks++;
    if (ctl() !== 4'b1100 || ramaddr !== 32'd0) begin
      n_fail++; $display("FAIL dblock_idle: got %b addr %h expected 1100 0", ctl(), ramaddr);
    end
    tick();
    ramstate = ACCESS; ramload = 32'h55; #1;
    n_checks++;
    if (ctl() !== 4'b0110 || ramaddr !== 32'h80 || iload !== 32'h55) begin
      n_fail++; $display("FAIL dblock_igrant: got %b addr %h iload %h expected 0110 80 55", ctl(), ramaddr, iload);
    end
    tick();
    iREN = 0; ramstate = FREE;
  endtask

  task automatic test_alternate();
    do_reset();
    dREN = 1; daddr = 32'h300; iREN = 1; iaddr = 32'h44;
    tick();
    ramstate = ACCESS; ramload = 32'h11; #1;
    n_checks++;
    if (ctl() !== 4'b1010 || ramaddr !== 32'h300 || dload !== 32'h11 || iload !== 32'd0) begin
      n_fail++;
      $display("FAIL alt_d0: got %b addr %h dload %h iload %h expected 1010 300 11 0", ctl(), ramaddr, dload, iload);
    end
    tick();
    daddr = 32'h304; ramload = 32'h22; #1;
    n_checks++;
    if (ctl() !== 4'b1010 || ramaddr !== 32'h304 || dload !== 32'h22) begin
      n_fail++; $display("FAIL alt_d1: got %b addr %h dload %h expected 1010 304 22", ctl(), ramaddr, dload);
    end
    tick();
    daddr = 32'h400; ramstate = FREE; #1;
    n_checks++;
    if (ctl() !== 4'b1100) begin n_fail++; $display("FAIL alt_idle: got %b expected 1100", ctl()); end
    tick();
    ramstate = ACCESS; ramload = 32'h33; #1;
    n_checks++;
    if (ctl() !== 4'b0110 || ramaddr !== 32'h44 || iload !== 32'h33 || dload !== 32'd0) begin
      n_fail++;
      $display("FAIL alt_igrant: got %b addr %h iload %h dload %h expected 0110 44 33 0", ctl(), ramaddr, iload, dload);
    end
    tick();
    iREN = 0; dREN = 0; ramstate = FREE;
    tick();
  endtask

  task automatic test_drop();
    logic [1:0] hold_st [3];
    hold_st[0] = BUSY; hold_st[1] = FREE; hold_st[2] = ERROR;
    do_reset();
    dREN = 1; daddr = 32'h500; iREN = 1; iaddr = 32'h48;
    tick();
    for (int c = 0; c < 3; c++) begin
      ramstate = hold_st[c]; ramload = 32'h99; #1;
      n_checks++;
      if (ctl() !== 4'b1110 || ramaddr !== 32'h500) begin
        n_fail++; $display("FAIL drop_hold[%0d]: got %b addr %h expected 1110 500", c, ctl(), ramaddr);
      end
      tick();
    end
    dREN = 0; ramstate = FREE; #1;
    n_checks++;
    if (ctl() !== 4'b1100) begin n_fail++; $display("FAIL drop_release: got %b expected 1100", ctl()); end
    tick();
    #1;
    n_checks++;
    if (ctl() !== 4'b1100 || ramaddr !== 32'd0) begin
      n_fail++; $display("FAIL drop_idle: got %b addr %h expected 1100 0", ctl(), ramaddr);
    end
    tick();
    ramstate = ACCESS; ramload = 32'h66; #1;
    n_checks++;
    if (ctl() !== 4'b0110 || ramaddr !== 32'h48 || iload !== 32'h66) begin
      n_fail++; $display("FAIL drop_igrant: got %b addr %h iload %h expected 0110 48 66", ctl(), ramaddr, iload);
    end
    tick();
    iREN = 0; ramstate = FREE;
  endtask

  task automatic test_reset_mid();
    do_reset();
    dREN = 1; daddr = 32'h200;
    tick();
    ramstate = ACCESS; ramload = 32'h12; #1;
    n_checks++;
    if (ctl() !== 4'b1010 || dload !== 32'h12) begin
      n_fail++; $display("FAIL rmid_w0: got %b dload %h expected 1010 12", ctl(), dload);
    end
    tick();
    RST = 1; daddr = 32'h204; ramstate = BUSY; #1;
    n_checks++;
    if (ctl() !== 4'b1110 || ramaddr !== 32'h204) begin
      n_fail++; $display("FAIL rmid_locked: got %b addr %h expected 1110 204", ctl(), ramaddr);
    end
    tick();
    RST = 0; dREN = 0; iREN = 1; iaddr = 32'h4C; ramstate = ACCESS; #1;
    n_checks++;
    if (ctl() !== 4'b1100 || ramaddr !== 32'd0 || dload !== 32'd0) begin
      n_fail++; $display("FAIL rmid_idle: got %b addr %h dload %h expected 1100 0 0", ctl(), ramaddr, dload);
    end
    tick();
    ramload = 32'h4C4C; #1;
    n_checks++;
    if (ctl() !== 4'b0110 || ramaddr !== 32'h4C || iload !== 32'h4C4C) begin
      n_fail++; $display("FAIL rmid_igrant: got %b addr %h iload %h expected 0110 4c 4c4c", ctl(), ramaddr, iload);
    end
    tick();
    iREN = 0; ramstate = FREE;
  endtask

  initial begin
    test_reset();
    test_iread();
    test_dblock();
    test_alternate();
    test_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
